// File: rtl/nes_video_scaler.sv
// rtl/nes_video_scaler.sv - integer-scaled NES framebuffer to raster video with border and syncs
// Raster counters -> framebuffer read issue -> registered palette/output stage.
module nes_video_scaler #(
   parameter int H_ACTIVE = 1920,
   parameter int H_FP     = 88,
   parameter int H_SYNC   = 44,
   parameter int H_BP     = 148,
   parameter int V_ACTIVE = 1080,
   parameter int V_FP     = 4,
   parameter int V_SYNC   = 5,
   parameter int V_BP     = 36,
   parameter int SRC_W    = 256,
   parameter int SRC_H    = 240,
   parameter int SYNC_POL = 1
) (
   input  logic        clk_pixel,
   input  logic        rst_pixel,
   input  logic [1:0]  scale_sel,
   input  logic [23:0] border_rgb,
   output logic        fb_ren,
   output logic [15:0] fb_raddr,
   input  logic [5:0]  fb_rdata,
   output logic        de,
   output logic        hsync,
   output logic        vsync,
   output logic [23:0] rgb,
   output logic        frame_start
);
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW = $clog2(H_TOTAL);
   localparam int VW = $clog2(V_TOTAL);
   localparam logic [HW-1:0] LINE   = HW'(H_TOTAL - 1);
   localparam logic [VW-1:0] SCREEN = VW'(V_TOTAL - 1);
   localparam logic [HW-1:0] HA     = HW'(H_ACTIVE);
   localparam logic [HW-1:0] HS_ON  = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] HS_OFF = HW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [VW-1:0] VA     = VW'(V_ACTIVE);
   localparam logic [VW-1:0] VS_ON  = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] VS_OFF = VW'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic SP = (SYNC_POL != 0);

   // Largest scale (1..4) whose image still fits the active area.
   localparam int FIT_H  = H_ACTIVE / SRC_W;
   localparam int FIT_V  = V_ACTIVE / SRC_H;
   localparam int FIT_HV = (FIT_H < FIT_V) ? FIT_H : FIT_V;
   localparam int S_MAX  = (FIT_HV > 4) ? 4 : ((FIT_HV < 1) ? 1 : FIT_HV);
   localparam logic [2:0] S_MAX3 = 3'(S_MAX);
   localparam logic [HW-1:0] X_OFF_R = HW'((H_ACTIVE - SRC_W * S_MAX) / 2);
   localparam logic [HW-1:0] X_END_R = HW'((H_ACTIVE - SRC_W * S_MAX) / 2 + SRC_W * S_MAX);
   localparam logic [VW-1:0] Y_OFF_R = VW'((V_ACTIVE - SRC_H * S_MAX) / 2);
   localparam logic [VW-1:0] Y_END_R = VW'((V_ACTIVE - SRC_H * S_MAX) / 2 + SRC_H * S_MAX);

   localparam logic [23:0] PALETTE [64] = '{
      24'h545454, 24'h001E74, 24'h081090, 24'h300088, 24'h440064, 24'h5C0030, 24'h540400, 24'h3C1800,
      24'h202A00, 24'h083A00, 24'h004000, 24'h003C00, 24'h00323C, 24'h000000, 24'h000000, 24'h000000,
      24'h989698, 24'h084CC4, 24'h3032EC, 24'h5C1EE4, 24'h8814B0, 24'hA01464, 24'h982220, 24'h783C00,
      24'h545A00, 24'h287200, 24'h087C00, 24'h007628, 24'h006678, 24'h000000, 24'h000000, 24'h000000,
      24'hECEEEC, 24'h4C9AEC, 24'h787CEC, 24'hB062EC, 24'hE454EC, 24'hEC58B4, 24'hEC6A64, 24'hD48820,
      24'hA0AA00, 24'h74C400, 24'h4CD020, 24'h38CC6C, 24'h38B4CC, 24'h3C3C3C, 24'h000000, 24'h000000,
      24'hECEEEC, 24'hA8CCEC, 24'hBCBCEC, 24'hD4B2EC, 24'hECAEEC, 24'hECAED4, 24'hECB4B0, 24'hE4C490,
      24'hCCD278, 24'hB4DE78, 24'hA8E290, 24'h98E2B4, 24'hA0D6E4, 24'hA0A2A0, 24'h000000, 24'h000000
   };

   logic          run_q, run_d;
   logic [HW-1:0] sx_q, sx_d, x_off_q, x_off_d, x_end_q, x_end_d;
   logic [VW-1:0] sy_q, sy_d, y_off_q, y_off_d, y_end_q, y_end_d;
   logic [2:0]    s_q, s_d, s_req, s_new;
   logic [1:0]    rx_q, rx_d, ry_q, ry_d, s_m1;
   logic [7:0]    fx_q, fx_d, fy_q, fy_d;
   logic [15:0]   addr_q, addr_d;
   logic          de1_q, de1_d, hs1_q, hs1_d, vs1_q, vs1_d, win1_q, win1_d, fs1_q, fs1_d;
   logic          de_q, de_d, hs_q, hs_d, vs_q, vs_d, fs_q, fs_d;
   logic [23:0]   rgb_q, rgb_d;
   logic          in_x, in_y, in_win, last_x, last_y;
   int            win_w, win_h;

   always_comb begin
      in_x   = (sx_q >= x_off_q) && (sx_q < x_end_q);
      in_y   = (sy_q >= y_off_q) && (sy_q < y_end_q);
      in_win = run_q && in_x && in_y;
      last_x = (sx_q == LINE);
      last_y = (sy_q == SCREEN);
      s_m1   = 2'(s_q - 3'd1);
      s_req  = {1'b0, scale_sel} + 3'd1;
      s_new  = (s_req > S_MAX3) ? S_MAX3 : s_req;
      win_w  = SRC_W * int'(s_new);
      win_h  = SRC_H * int'(s_new);

      run_d   = 1'b1;
      sx_d    = sx_q;
      sy_d    = sy_q;
      s_d     = s_q;
      x_off_d = x_off_q;
      x_end_d = x_end_q;
      y_off_d = y_off_q;
      y_end_d = y_end_q;
      rx_d    = rx_q;
      fx_d    = fx_q;
      ry_d    = ry_q;
      fy_d    = fy_q;

      // Counters hold at (0,0) for the first edge after reset so that pixel owns a full cycle.
      if (run_q) begin
         if (last_x) begin
            sx_d = '0;
            sy_d = last_y ? '0 : sy_q + 1'b1;
         end else begin
            sx_d = sx_q + 1'b1;
         end
         if (last_x && last_y) begin
            s_d     = s_new;
            x_off_d = HW'((H_ACTIVE - win_w) / 2);
            x_end_d = HW'((H_ACTIVE - win_w) / 2 + win_w);
            y_off_d = VW'((V_ACTIVE - win_h) / 2);
            y_end_d = VW'((V_ACTIVE - win_h) / 2 + win_h);
         end
      end

      if (in_win) begin
         rx_d = (rx_q == s_m1) ? 2'd0 : rx_q + 2'd1;
         fx_d = (rx_q == s_m1) ? fx_q + 8'd1 : fx_q;
      end else begin
         rx_d = 2'd0;
         fx_d = 8'd0;
      end

      if (run_q && last_x) begin
         if (in_y && !last_y) begin
            ry_d = (ry_q == s_m1) ? 2'd0 : ry_q + 2'd1;
            fy_d = (ry_q == s_m1) ? fy_q + 8'd1 : fy_q;
         end else begin
            ry_d = 2'd0;
            fy_d = 8'd0;
         end
      end

      fb_ren   = in_win;
      fb_raddr = in_win ? {fy_q, fx_q} : addr_q;
      addr_d   = fb_raddr;

      de1_d  = run_q && (sx_q < HA) && (sy_q < VA);
      hs1_d  = (run_q && (sx_q >= HS_ON) && (sx_q < HS_OFF)) ? SP : ~SP;
      vs1_d  = (run_q && (sy_q >= VS_ON) && (sy_q < VS_OFF)) ? SP : ~SP;
      win1_d = in_win;
      fs1_d  = run_q && (sx_q == '0) && (sy_q == '0);

      de_d  = de1_q;
      hs_d  = hs1_q;
      vs_d  = vs1_q;
      fs_d  = fs1_q;
      rgb_d = !de1_q ? 24'h0 : (win1_q ? PALETTE[fb_rdata] : border_rgb);
   end

   always_ff @(posedge clk_pixel or posedge rst_pixel) begin
      if (rst_pixel) begin
         run_q   <= 1'b0;
         sx_q    <= '0;
         sy_q    <= '0;
         s_q     <= S_MAX3;
         x_off_q <= X_OFF_R;
         x_end_q <= X_END_R;
         y_off_q <= Y_OFF_R;
         y_end_q <= Y_END_R;
         rx_q    <= 2'd0;
         fx_q    <= 8'd0;
         ry_q    <= 2'd0;
         fy_q    <= 8'd0;
         addr_q  <= 16'd0;
         de1_q   <= 1'b0;
         hs1_q   <= ~SP;
         vs1_q   <= ~SP;
         win1_q  <= 1'b0;
         fs1_q   <= 1'b0;
         de_q    <= 1'b0;
         hs_q    <= ~SP;
         vs_q    <= ~SP;
         fs_q    <= 1'b0;
         rgb_q   <= 24'h0;
      end else begin
         run_q   <= run_d;
         sx_q    <= sx_d;
         sy_q    <= sy_d;
         s_q     <= s_d;
         x_off_q <= x_off_d;
         x_end_q <= x_end_d;
         y_off_q <= y_off_d;
         y_end_q <= y_end_d;
         rx_q    <= rx_d;
         fx_q    <= fx_d;
         ry_q    <= ry_d;
         fy_q    <= fy_d;
         addr_q  <= addr_d;
         de1_q   <= de1_d;
         hs1_q   <= hs1_d;
         vs1_q   <= vs1_d;
         win1_q  <= win1_d;
         fs1_q   <= fs1_d;
         de_q    <= de_d;
         hs_q    <= hs_d;
         vs_q    <= vs_d;
         fs_q    <= fs_d;
         rgb_q   <= rgb_d;
      end
   end

   assign de          = de_q;
   assign hsync       = hs_q;
   assign vsync       = vs_q;
   assign frame_start = fs_q;
   assign rgb         = rgb_q;
endmodule

// File: tb/tb_nes_video_scaler.sv
// tb/tb_nes_video_scaler.sv - randomized reference-model bench for nes_video_scaler
// Small rasters keep frames short; a second instance covers scale clamping and low sync polarity.
module tb_nes_video_scaler;
   localparam int HA = 40, HF = 3, HS = 4, HB = 5;
   localparam int VA = 30, VF = 2, VS = 3, VB = 2;
   localparam int SW = 8, SH = 6;
   localparam int HT = HA + HF + HS + HB;
   localparam int VT = VA + VF + VS + VB;
   localparam int FT = HT * VT;
   localparam int HT2 = 36, VT2 = 18, FT2 = HT2 * VT2;

   typedef struct packed {
      logic        de;
      logic        hs;
      logic        vs;
      logic        fs;
      logic        win;
      logic [15:0] addr;
      logic [23:0] rgb;
   } rec_t;

   logic        clk;
   logic        rst;
   logic [1:0]  scale_sel;
   logic [23:0] border_rgb;
   logic [5:0]  fb_rdata, fb_rdata2;
   logic        fb_ren, de, hsync, vsync, frame_start;
   logic [15:0] fb_raddr;
   logic [23:0] rgb;
   logic        fb_ren2, de2, hsync2, vsync2, frame_start2;
   logic [15:0] fb_raddr2;
   logic [23:0] rgb2;

   nes_video_scaler #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
                      .SRC_W(SW), .SRC_H(SH), .SYNC_POL(1)) dut (
      .clk_pixel(clk), .rst_pixel(rst), .scale_sel(scale_sel), .border_rgb(border_rgb),
      .fb_ren(fb_ren), .fb_raddr(fb_raddr), .fb_rdata(fb_rdata), .de(de),
      .hsync(hsync), .vsync(vsync), .rgb(rgb), .frame_start(frame_start));

   nes_video_scaler #(.H_ACTIVE(28), .H_FP(2), .H_SYNC(3), .H_BP(3),
                      .V_ACTIVE(14), .V_FP(1), .V_SYNC(2), .V_BP(1),
                      .SRC_W(SW), .SRC_H(SH), .SYNC_POL(0)) dut2 (
      .clk_pixel(clk), .rst_pixel(rst), .scale_sel(scale_sel), .border_rgb(border_rgb),
      .fb_ren(fb_ren2), .fb_raddr(fb_raddr2), .fb_rdata(fb_rdata2), .de(de2),
      .hsync(hsync2), .vsync(vsync2), .rgb(rgb2), .frame_start(frame_start2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [23:0] pal [64];
   logic [5:0]  mem [65536];
   int          n_cmp, n_bad;
   int          p, m_scale, m_next_scale;
   rec_t        e1, e2, idle;
   logic [15:0] m_last;
   logic [5:0]  rd_next;
   logic        first_run;
   int          x2_min, x2_max, y2_min, y2_max, ren2_cnt, hs2_cnt, vs2_cnt, de2_cnt;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (pixel %0d, t=%0t)", tag, got, exp, p, $time);
      end
   endtask

   function automatic int clamp(input int r);
      for (int s = r; s >= 1; s--)
         if (SW * s <= HA && SH * s <= VA) return s;
      return 1;
   endfunction

   function automatic rec_t model_pixel(input int pix, input int s);
      rec_t r;
      int sx, sy, xo, yo;
      sx = pix % HT;
      sy = (pix / HT) % VT;
      xo = (HA - SW * s) / 2;
      yo = (VA - SH * s) / 2;
      r.de   = (sx < HA) && (sy < VA);
      r.hs   = (sx >= HA + HF) && (sx < HA + HF + HS);
      r.vs   = (sy >= VA + VF) && (sy < VA + VF + VS);
      r.fs   = (sx == 0) && (sy == 0);
      r.win  = (sx >= xo) && (sx < xo + SW * s) && (sy >= yo) && (sy < yo + SH * s);
      r.addr = {8'((sy - yo) / s), 8'((sx - xo) / s)};
      r.rgb  = 24'h0;
      return r;
   endfunction

   task automatic model_reset();
      p            = 0;
      m_scale      = clamp(4);
      m_next_scale = m_scale;
      e1           = idle;
      e2           = idle;
      m_last       = 16'h0;
      rd_next      = 6'($urandom);
   endtask

   task automatic sample();
      rec_t cur;
      int   x2, y2;
      @(posedge clk);
      #1;
      fb_rdata  = rd_next;
      fb_rdata2 = 6'($urandom);
      check_eq("de", 32'(de), 32'(e2.de));
      check_eq("hsync", 32'(hsync), 32'(e2.hs));
      check_eq("vsync", 32'(vsync), 32'(e2.vs));
      check_eq("frame_start", 32'(frame_start), 32'(e2.fs));
      check_eq("rgb", 32'(rgb), 32'(e2.rgb));
      if (p > 0 && p % FT == 0) m_scale = m_next_scale;
      cur = model_pixel(p, m_scale);
      check_eq("fb_ren", 32'(fb_ren), 32'(cur.win));
      check_eq("fb_raddr", 32'(fb_raddr), 32'(cur.win ? cur.addr : m_last));
      if (cur.win) m_last = cur.addr;
      rd_next = fb_ren ? mem[fb_raddr] : 6'($urandom);
      e1.rgb  = cur.rgb;
      if (first_run && p >= FT2 && p < 2 * FT2 && fb_ren2) begin
         x2 = p % HT2;
         y2 = (p / HT2) % VT2;
         if (x2 < x2_min) x2_min = x2;
         if (x2 > x2_max) x2_max = x2;
         if (y2 < y2_min) y2_min = y2;
         if (y2 > y2_max) y2_max = y2;
         ren2_cnt++;
      end
      if (first_run && p >= 2 && p < FT2 + 2) begin
         if (!hsync2) hs2_cnt++;
         if (!vsync2) vs2_cnt++;
         if (de2) de2_cnt++;
      end
      e2     = e1;
      e2.rgb = !e1.de ? 24'h0 : (e1.win ? pal[mem[e1.addr]] : 24'h0);
      e1     = cur;
   endtask

   // Runs after any stimulus change: border is sampled by the output stage at the coming edge.
   task automatic commit();
      if (e2.de && !e2.win) e2.rgb = border_rgb;
      if (p % FT == FT - 1) m_next_scale = clamp(int'(scale_sel) + 1);
      p++;
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_de"}, 32'(de), 32'd0);
      check_eq({tag, "_rgb"}, 32'(rgb), 32'd0);
      check_eq({tag, "_frame_start"}, 32'(frame_start), 32'd0);
      check_eq({tag, "_fb_ren"}, 32'(fb_ren), 32'd0);
      check_eq({tag, "_fb_raddr"}, 32'(fb_raddr), 32'd0);
      check_eq({tag, "_hsync"}, 32'(hsync), 32'd0);
      check_eq({tag, "_vsync"}, 32'(vsync), 32'd0);
      check_eq({tag, "_hsync_lowpol"}, 32'(hsync2), 32'd1);
      check_eq({tag, "_vsync_lowpol"}, 32'(vsync2), 32'd1);
   endtask

   initial begin
      pal = '{
         24'h545454, 24'h001E74, 24'h081090, 24'h300088, 24'h440064, 24'h5C0030, 24'h540400, 24'h3C1800,
         24'h202A00, 24'h083A00, 24'h004000, 24'h003C00, 24'h00323C, 24'h000000, 24'h000000, 24'h000000,
         24'h989698, 24'h084CC4, 24'h3032EC, 24'h5C1EE4, 24'h8814B0, 24'hA01464, 24'h982220, 24'h783C00,
         24'h545A00, 24'h287200, 24'h087C00, 24'h007628, 24'h006678, 24'h000000, 24'h000000, 24'h000000,
         24'hECEEEC, 24'h4C9AEC, 24'h787CEC, 24'hB062EC, 24'hE454EC, 24'hEC58B4, 24'hEC6A64, 24'hD48820,
         24'hA0AA00, 24'h74C400, 24'h4CD020, 24'h38CC6C, 24'h38B4CC, 24'h3C3C3C, 24'h000000, 24'h000000,
         24'hECEEEC, 24'hA8CCEC, 24'hBCBCEC, 24'hD4B2EC, 24'hECAEEC, 24'hECAED4, 24'hECB4B0, 24'hE4C490,
         24'hCCD278, 24'hB4DE78, 24'hA8E290, 24'h98E2B4, 24'hA0D6E4, 24'hA0A2A0, 24'h000000, 24'h000000
      };
      for (int i = 0; i < 65536; i++) mem[i] = 6'($urandom);
      mem[16'h0000] = 6'd0;
      mem[16'h0001] = 6'd13;
      mem[16'h0002] = 6'd32;
      n_cmp = 0; n_bad = 0;
      idle = '0;
      x2_min = 999; x2_max = -1; y2_min = 999; y2_max = -1;
      ren2_cnt = 0; hs2_cnt = 0; vs2_cnt = 0; de2_cnt = 0;
      first_run  = 1'b1;
      rst        = 1'b1;
      scale_sel  = 2'd3;
      border_rgb = 24'h123456;
      fb_rdata   = 6'd0;
      fb_rdata2  = 6'd0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      @(negedge clk);
      rst = 1'b0;

      for (int f = 0; f < 5; f++) begin
         int cq;
         cq = $urandom_range(0, FT - 1);
         for (int q = 0; q < FT; q++) begin
            sample();
            if (f == 1 && q == 15 * HT) scale_sel = 2'd0;
            if (f == 2 && q == 5 * HT) begin scale_sel = 2'd1; border_rgb = 24'($urandom); end
            if (f == 3 && q == cq) begin scale_sel = 2'($urandom); border_rgb = 24'($urandom); end
            if (f == 4 && q == 10 * HT + 20) break;
            commit();
         end
      end

      check_eq("clamp_x_min", 32'(x2_min), 32'd6);
      check_eq("clamp_x_max", 32'(x2_max), 32'd21);
      check_eq("clamp_y_min", 32'(y2_min), 32'd1);
      check_eq("clamp_y_max", 32'(y2_max), 32'd12);
      check_eq("clamp_ren_count", 32'(ren2_cnt), 32'd192);
      check_eq("lowpol_hsync_count", 32'(hs2_cnt), 32'(3 * VT2));
      check_eq("lowpol_vsync_count", 32'(vs2_cnt), 32'(2 * HT2));
      check_eq("lowpol_de_count", 32'(de2_cnt), 32'(28 * 14));

      // Mid-frame reset: outputs clear without waiting for a clock edge.
      rst = 1'b1;
      #1;
      check_reset_outputs("midreset");
      first_run = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      model_reset();
      rst = 1'b0;

      for (int f = 0; f < 2; f++) begin
         int cq;
         cq = $urandom_range(0, FT - 1);
         for (int q = 0; q < FT; q++) begin
            sample();
            if (q == cq) begin scale_sel = 2'($urandom); border_rgb = 24'($urandom); end
            commit();
         end
      end
      repeat (3) begin
         sample();
         commit();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
